// File: rtl/mux_pipe_skid_if.sv
// Producer/consumer bundle for mux_pipe_skid: input beat handshake with
// channel select, output beat handshake with select-error flag.
interface mux_pipe_skid_if #(
    parameter int WIDTH  = 64,
    parameter int NUM_IN = 4,
    parameter int ONEHOT = 0
);
    localparam int SEL_W = (ONEHOT != 0) ? NUM_IN
                         : (($clog2(NUM_IN) > 1) ? $clog2(NUM_IN) : 1);

    logic                    in_valid;
    logic                    in_ready;
    logic [SEL_W-1:0]        in_sel;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_err;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/mux_pipe_skid.sv
// N-input selector feeding a registered valid/ready stage with a one-entry
// skid buffer; in_ready is registered so it never depends on out_ready.
module mux_pipe_skid #(
    parameter int WIDTH  = 64,
    parameter int NUM_IN = 4,
    parameter int ONEHOT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    mux_pipe_skid_if.slave     bus
);
    localparam int SEL_W = (ONEHOT != 0) ? NUM_IN
                         : (($clog2(NUM_IN) > 1) ? $clog2(NUM_IN) : 1);

    typedef struct packed {
        logic             err;
        logic [WIDTH-1:0] data;
    } beat_t;

    beat_t w_sel_beat;
    beat_t r_main;
    beat_t r_skid;
    logic  r_main_vld;
    logic  r_skid_vld;
    logic  r_in_rdy;
    logic  w_in_hs;
    logic  w_out_hs;

    generate
        if (ONEHOT != 0) begin : g_onehot
            // Descending scan so the lowest set bit is the last writer and wins.
            always_comb begin
                w_sel_beat     = '0;
                w_sel_beat.err = 1'b1;
                for (int i = NUM_IN - 1; i >= 0; i--) begin
                    if (bus.in_sel[i]) begin
                        w_sel_beat.err  = 1'b0;
                        w_sel_beat.data = bus.in_data[i*WIDTH +: WIDTH];
                    end
                end
            end
        end else begin : g_bin
            always_comb begin
                w_sel_beat     = '0;
                w_sel_beat.err = 1'b1;
                for (int i = 0; i < NUM_IN; i++) begin
                    if (bus.in_sel == SEL_W'(i)) begin
                        w_sel_beat.err  = 1'b0;
                        w_sel_beat.data = bus.in_data[i*WIDTH +: WIDTH];
                    end
                end
            end
        end
    endgenerate

    assign w_in_hs  = bus.in_valid & r_in_rdy;
    assign w_out_hs = r_main_vld & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main     <= '0;
            r_skid     <= '0;
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_rdy   <= 1'b0;
        end else if (flush) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_rdy   <= 1'b1;
        end else if (!r_main_vld || w_out_hs) begin
            // Main slot frees up: skid beat first (in_ready was low, so no new beat competes).
            if (r_skid_vld) begin
                r_main     <= r_skid;
                r_main_vld <= 1'b1;
                r_skid_vld <= 1'b0;
            end else if (w_in_hs) begin
                r_main     <= w_sel_beat;
                r_main_vld <= 1'b1;
            end else begin
                r_main_vld <= 1'b0;
            end
            r_in_rdy <= 1'b1;
        end else begin
            if (w_in_hs) begin
                r_skid     <= w_sel_beat;
                r_skid_vld <= 1'b1;
            end
            r_in_rdy <= ~(r_skid_vld | w_in_hs);
        end
    end

    assign bus.in_ready  = r_in_rdy;
    assign bus.out_valid = r_main_vld;
    assign bus.out_data  = r_main.data;
    assign bus.out_err   = r_main.err;
endmodule

// File: tb/tb_mux_pipe_skid.sv
// Directed checks on binary (4x64, 3x32) and one-hot (4x64) instances, then a
// randomized handshake run on the 3x32 instance against an in-order queue model.
module tb_mux_pipe_skid;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    localparam logic [63:0] C0 = 64'h1111111111111111;
    localparam logic [63:0] C1 = 64'h2222222222222222;
    localparam logic [63:0] C2 = 64'h3333333333333333;
    localparam logic [63:0] C3 = 64'h4444444444444444;

    mux_pipe_skid_if #(.WIDTH(64), .NUM_IN(4), .ONEHOT(0)) b0();
    mux_pipe_skid_if #(.WIDTH(32), .NUM_IN(3), .ONEHOT(0)) b1();
    mux_pipe_skid_if #(.WIDTH(64), .NUM_IN(4), .ONEHOT(1)) b2();

    mux_pipe_skid #(.WIDTH(64), .NUM_IN(4), .ONEHOT(0)) u0 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b0));
    mux_pipe_skid #(.WIDTH(32), .NUM_IN(3), .ONEHOT(0)) u1 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b1));
    mux_pipe_skid #(.WIDTH(64), .NUM_IN(4), .ONEHOT(1)) u2 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    logic [32:0] q[$];
    logic [32:0] e;
    logic [95:0] d;
    int acc = 0;
    int got = 0;
    int ncyc = 0;

    initial begin
        b0.in_valid = 1'b0; b0.in_sel = '0; b0.out_ready = 1'b0;
        b0.in_data  = {C3, C2, C1, C0};
        b1.in_valid = 1'b0; b1.in_sel = '0; b1.out_ready = 1'b0;
        b1.in_data  = {32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
        b2.in_valid = 1'b0; b2.in_sel = '0; b2.out_ready = 1'b0;
        b2.in_data  = {C3, C2, C1, C0};

        // reset state
        repeat (2) cyc();
        chk("rst_ovld", 64'(b0.out_valid), 64'd0);
        chk("rst_irdy", 64'(b0.in_ready), 64'd0);
        chk("rst_odata", b0.out_data, 64'd0);
        chk("rst_oerr", 64'(b0.out_err), 64'd0);
        rst_n = 1'b1;
        #1 chk("irdy_low_before_edge", 64'(b0.in_ready), 64'd0);
        cyc();
        chk("irdy_after_edge", 64'(b0.in_ready), 64'd1);

        // streaming, one beat per cycle
        b0.out_ready = 1'b1; b0.in_valid = 1'b1; b0.in_sel = 2'd2;
        cyc();
        chk("bin_s2_data", b0.out_data, C2);
        chk("bin_s2_vld", 64'(b0.out_valid), 64'd1);
        chk("bin_s2_err", 64'(b0.out_err), 64'd0);
        b0.in_sel = 2'd0; cyc();
        chk("strm_c0", b0.out_data, C0);
        chk("strm_c0_vld", 64'(b0.out_valid), 64'd1);
        b0.in_sel = 2'd3; cyc();
        chk("strm_c3", b0.out_data, C3);
        b0.in_sel = 2'd1; cyc();
        chk("strm_c1", b0.out_data, C1);
        b0.in_valid = 1'b0; cyc();
        chk("strm_empty", 64'(b0.out_valid), 64'd0);
        chk("strm_hold", b0.out_data, C1);

        // backpressure: A on main, B into skid, C refused
        b0.out_ready = 1'b0; b0.in_valid = 1'b1; b0.in_sel = 2'd0; cyc();
        chk("bp_a", b0.out_data, C0);
        chk("bp_a_irdy", 64'(b0.in_ready), 64'd1);
        b0.in_sel = 2'd1; cyc();
        chk("bp_a_hold", b0.out_data, C0);
        chk("bp_skid_irdy", 64'(b0.in_ready), 64'd0);
        b0.in_sel = 2'd2; cyc();
        chk("bp_a_hold2", b0.out_data, C0);
        chk("bp_vld_hold", 64'(b0.out_valid), 64'd1);
        chk("bp_irdy_hold", 64'(b0.in_ready), 64'd0);
        b0.in_valid = 1'b0; b0.out_ready = 1'b1; cyc();
        chk("bp_b", b0.out_data, C1);
        chk("bp_b_vld", 64'(b0.out_valid), 64'd1);
        chk("bp_irdy_back", 64'(b0.in_ready), 64'd1);
        cyc();
        chk("bp_drained", 64'(b0.out_valid), 64'd0);

        // flush with main+skid full, then flush discarding a live handshake
        b0.out_ready = 1'b0; b0.in_valid = 1'b1; b0.in_sel = 2'd0; cyc();
        b0.in_sel = 2'd1; cyc();
        chk("fl_full_irdy", 64'(b0.in_ready), 64'd0);
        flush = 1'b1; b0.in_sel = 2'd2; cyc();
        chk("fl_vld", 64'(b0.out_valid), 64'd0);
        chk("fl_irdy", 64'(b0.in_ready), 64'd1);
        b0.in_sel = 2'd3; cyc();
        chk("fl_hs_dropped", 64'(b0.out_valid), 64'd0);
        flush = 1'b0; b0.in_valid = 1'b0; b0.out_ready = 1'b1; cyc();
        chk("fl_nothing_out", 64'(b0.out_valid), 64'd0);

        // asynchronous reset mid-transfer
        b0.out_ready = 1'b0; b0.in_valid = 1'b1; b0.in_sel = 2'd3; cyc();
        b0.in_sel = 2'd0; cyc();
        chk("ar_pre_vld", 64'(b0.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_vld_drop", 64'(b0.out_valid), 64'd0);
        chk("ar_irdy_drop", 64'(b0.in_ready), 64'd0);
        chk("ar_data_clr", b0.out_data, 64'd0);
        b0.in_valid = 1'b0;
        cyc();
        rst_n = 1'b1; cyc();
        chk("ar_irdy_up", 64'(b0.in_ready), 64'd1);
        b0.in_valid = 1'b1; b0.in_sel = 2'd1; b0.out_ready = 1'b1; cyc();
        chk("ar_first", b0.out_data, C1);
        chk("ar_first_vld", 64'(b0.out_valid), 64'd1);
        b0.in_valid = 1'b0; cyc();
        chk("ar_no_stale", 64'(b0.out_valid), 64'd0);

        // select errors (binary 3-input) and one-hot priority
        b1.out_ready = 1'b1; b2.out_ready = 1'b1;
        b1.in_valid = 1'b1; b1.in_sel = 2'd3;
        b2.in_valid = 1'b1; b2.in_sel = 4'b0110;
        cyc();
        chk("bin_bad_data", 64'(b1.out_data), 64'd0);
        chk("bin_bad_err", 64'(b1.out_err), 64'd1);
        chk("bin_bad_vld", 64'(b1.out_valid), 64'd1);
        chk("oh_0110_data", b2.out_data, C1);
        chk("oh_0110_err", 64'(b2.out_err), 64'd0);
        b1.in_sel = 2'd2; b2.in_sel = 4'b0000; cyc();
        chk("bin_s2_w32", 64'(b1.out_data), 64'hC2C2C2C2);
        chk("bin_s2_w32_err", 64'(b1.out_err), 64'd0);
        chk("oh_zero_data", b2.out_data, 64'd0);
        chk("oh_zero_err", 64'(b2.out_err), 64'd1);
        b1.in_sel = 2'd0; b2.in_sel = 4'b1000; cyc();
        chk("bin_s0_w32", 64'(b1.out_data), 64'hA0A0A0A0);
        chk("oh_1000", b2.out_data, C3);
        b1.in_valid = 1'b0; b2.in_sel = 4'b1111; cyc();
        chk("oh_1111", b2.out_data, C0);
        b2.in_valid = 1'b0; cyc();

        // random handshakes on the 3x32 instance
        while ((acc < 10000 || q.size() != 0) && ncyc < 60000) begin
            d = {$urandom, $urandom, $urandom};
            b1.in_data   = d;
            b1.in_sel    = 2'($urandom_range(0, 3));
            b1.in_valid  = (acc < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            b1.out_ready = (acc < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (b1.out_valid && b1.out_ready) begin
                chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    got++;
                    chk("sb_data", 64'(b1.out_data), 64'(e[31:0]));
                    chk("sb_err", 64'(b1.out_err), 64'(e[32]));
                end
            end
            if (b1.in_valid && b1.in_ready) begin
                acc++;
                case (b1.in_sel)
                    2'd0:    q.push_back({1'b0, d[31:0]});
                    2'd1:    q.push_back({1'b0, d[63:32]});
                    2'd2:    q.push_back({1'b0, d[95:64]});
                    default: q.push_back({1'b1, 32'h0});
                endcase
            end
            cyc();
            ncyc++;
        end
        chk("sb_accepted", 64'(acc), 64'd10000);
        chk("sb_received", 64'(got), 64'd10000);
        chk("sb_drained", 64'(q.size()), 64'd0);
        chk("sb_final_empty", 64'(b1.out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
